// File: rtl/regfile_pkg.sv
// +--------------------------------------------------------------------+
// | regfile_pkg: shared constants and types for the integer regfile    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package regfile_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;
endpackage

`default_nettype wire

// File: rtl/regfile_read_port.sv
// +--------------------------------------------------------------------+
// | regfile_read_port: one combinational read port with x0 forcing and |
// | optional write bypass (REGFILE_WRITE_BYPASS_EN)                     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
    input  logic [ADDR_WIDTH-1:0]                      rd_addr,
`ifdef REGFILE_WRITE_BYPASS_EN
    input  logic                                       rst,
    input  logic                                       wr_en,
    input  logic [ADDR_WIDTH-1:0]                      wr_addr,
    input  logic [DATA_WIDTH-1:0]                      wr_data,
`endif
    output logic [DATA_WIDTH-1:0]                      rd_data
);

    always_comb begin
        rd_data = regs[rd_addr];
`ifdef REGFILE_WRITE_BYPASS_EN
        // Forward the in-flight write so the consumer sees it this cycle.
        if (wr_en && !rst && (wr_addr != '0) && (rd_addr == wr_addr)) begin
            rd_data = wr_data;
        end
`endif
        if (rd_addr == '0) begin
            rd_data = '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/register_file.sv
// +--------------------------------------------------------------------+
// | register_file: 2**ADDR_WIDTH x DATA_WIDTH integer register file,   |
// | 2 async read ports, 1 sync write port; macro REGFILE_WRITE_BYPASS_EN|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  regWrite,
    input  logic [ADDR_WIDTH-1:0] readRegister1,
    input  logic [ADDR_WIDTH-1:0] readRegister2,
    input  logic [ADDR_WIDTH-1:0] writeRegister,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2
);

    localparam int NUM_ENTRIES = 2**ADDR_WIDTH;

    logic [NUM_ENTRIES-1:0][DATA_WIDTH-1:0] regs;

    // Entry 0 is never written, so it stays at its reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else if (regWrite && (writeRegister != '0)) begin
            regs[writeRegister] <= writeData;
        end
    end

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_port1 (
        .regs    (regs),
        .rd_addr (readRegister1),
`ifdef REGFILE_WRITE_BYPASS_EN
        .rst     (rst),
        .wr_en   (regWrite),
        .wr_addr (writeRegister),
        .wr_data (writeData),
`endif
        .rd_data (readData1)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_port2 (
        .regs    (regs),
        .rd_addr (readRegister2),
`ifdef REGFILE_WRITE_BYPASS_EN
        .rst     (rst),
        .wr_en   (regWrite),
        .wr_addr (writeRegister),
        .wr_data (writeData),
`endif
        .rd_data (readData2)
    );

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// +--------------------------------------------------------------------+
// | tb_register_file: self-checking bench for register_file            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_register_file;
    import regfile_pkg::*;

    logic      clk;
    logic      rst;
    logic      regWrite;
    reg_addr_t readRegister1;
    reg_addr_t readRegister2;
    reg_addr_t writeRegister;
    xlen_t     writeData;
    xlen_t     readData1;
    xlen_t     readData2;

    int errors = 0;
    int checks = 0;

    xlen_t model [NUM_REGS];

    register_file dut (
        .clk           (clk),
        .rst           (rst),
        .regWrite      (regWrite),
        .readRegister1 (readRegister1),
        .readRegister2 (readRegister2),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .readData1     (readData1),
        .readData2     (readData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read value given the model and the inputs currently driven.
    function automatic xlen_t exp_read(input reg_addr_t addr);
        if (addr == 0) return '0;
        if (rst) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (regWrite && writeRegister != 0 && addr == writeRegister) return writeData;
`endif
        return model[addr];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    endfunction

    // Advance through one rising edge, applying the write to the model.
    task automatic clock_edge();
        @(posedge clk);
        if (!rst && regWrite && writeRegister != 0) model[writeRegister] = writeData;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; regWrite = 1'b0; writeRegister = '0; writeData = '0;
        readRegister1 = '0; readRegister2 = '0;
        model_clear();
        #12;
        rst = 1'b0;
        readRegister1 = 5'd1; readRegister2 = 5'd31;
        #1;
        checks++;
        if (readData1 !== 32'd0) begin
            errors++; $display("FAIL reset_rd1 got=%h exp=%h", readData1, 32'd0);
        end
        checks++;
        if (readData2 !== 32'd0) begin
            errors++; $display("FAIL reset_rd2 got=%h exp=%h", readData2, 32'd0);
        end
    endtask

    task automatic test_basic_write_read();
        regWrite = 1'b1; writeRegister = 5'd1; writeData = 32'd50;
        clock_edge();
        writeRegister = 5'd2; writeData = 32'd20;
        clock_edge();
        regWrite = 1'b0; readRegister1 = 5'd1; readRegister2 = 5'd2;
        #1;
        checks++;
        if (readData1 !== 32'd50) begin
            errors++; $display("FAIL basic_x1 got=%0d exp=%0d", readData1, 50);
        end
        checks++;
        if (readData2 !== 32'd20) begin
            errors++; $display("FAIL basic_x2 got=%0d exp=%0d", readData2, 20);
        end
    endtask

    task automatic test_write_disable_fullwidth();
        regWrite = 1'b1; writeRegister = 5'd3; writeData = 32'h8000_0005;
        clock_edge();
        regWrite = 1'b0; writeData = 32'd8; readRegister1 = 5'd3;
        #1;
        checks++;
        if (readData1 !== 32'd2147483653) begin
            errors++; $display("FAIL fullwidth_x3 got=%0d exp=%0d", readData1, 32'd2147483653);
        end
        clock_edge();
        checks++;
        if (readData1 !== 32'd2147483653) begin
            errors++; $display("FAIL wr_disabled_x3 got=%0d exp=%0d", readData1, 32'd2147483653);
        end
    endtask

    task automatic test_x0();
        regWrite = 1'b1; writeRegister = 5'd0; writeData = 32'd65547;
        readRegister1 = 5'd0; readRegister2 = 5'd0;
        #1;
        checks++;
        if (readData1 !== 32'd0) begin
            errors++; $display("FAIL x0_pre_edge got=%h exp=%h", readData1, 32'd0);
        end
        clock_edge();
        regWrite = 1'b0;
        #1;
        checks++;
        if (readData1 !== 32'd0) begin
            errors++; $display("FAIL x0_rd1 got=%h exp=%h", readData1, 32'd0);
        end
        checks++;
        if (readData2 !== 32'd0) begin
            errors++; $display("FAIL x0_rd2 got=%h exp=%h", readData2, 32'd0);
        end
        readRegister1 = 5'd1; readRegister2 = 5'd1;
        #1;
        checks++;
        if (readData1 !== 32'd50 || readData2 !== 32'd50) begin
            errors++; $display("FAIL same_reg_both_ports got=%0d/%0d exp=%0d", readData1, readData2, 50);
        end
    endtask

    task automatic test_async_reset();
        regWrite = 1'b1; writeRegister = 5'd5; writeData = 32'd28;
        clock_edge();
        regWrite = 1'b0; readRegister1 = 5'd5;
        #1;
        checks++;
        if (readData1 !== 32'd28) begin
            errors++; $display("FAIL x5_loaded got=%0d exp=%0d", readData1, 28);
        end
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        checks++;
        if (readData1 !== 32'd0) begin
            errors++; $display("FAIL async_clear got=%0d exp=%0d", readData1, 0);
        end
        regWrite = 1'b1; writeRegister = 5'd5; writeData = 32'd32;
        clock_edge();
        checks++;
        if (readData1 !== 32'd0) begin
            errors++; $display("FAIL write_during_rst got=%0d exp=%0d", readData1, 0);
        end
        regWrite = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (readData1 !== 32'd0) begin
            errors++; $display("FAIL after_rst_x5 got=%0d exp=%0d", readData1, 0);
        end
        // First edge after release must accept a write.
        regWrite = 1'b1; writeRegister = 5'd6; writeData = 32'd77; readRegister2 = 5'd6;
        clock_edge();
        regWrite = 1'b0;
        #1;
        checks++;
        if (readData2 !== 32'd77) begin
            errors++; $display("FAIL first_write_after_rst got=%0d exp=%0d", readData2, 77);
        end
    endtask

    task automatic test_same_cycle();
        xlen_t exp_pre;
        regWrite = 1'b1; writeRegister = 5'd4; writeData = 32'd10;
        clock_edge();
        writeData = 32'd32; readRegister1 = 5'd4;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        exp_pre = 32'd32;
`else
        exp_pre = 32'd10;
`endif
        checks++;
        if (readData1 !== exp_pre) begin
            errors++; $display("FAIL same_cycle_pre got=%0d exp=%0d", readData1, exp_pre);
        end
        clock_edge();
        regWrite = 1'b0;
        #1;
        checks++;
        if (readData1 !== 32'd32) begin
            errors++; $display("FAIL same_cycle_post got=%0d exp=%0d", readData1, 32);
        end
    endtask

    task automatic test_random();
        xlen_t e1, e2;
        for (int n = 0; n < 300; n++) begin
            regWrite      = ($urandom_range(0, 3) != 0);
            writeRegister = 5'($urandom_range(0, 31));
            writeData     = $urandom;
            readRegister1 = 5'($urandom_range(0, 31));
            readRegister2 = ($urandom_range(0, 3) == 0) ? writeRegister : 5'($urandom_range(0, 31));
            #1;
            e1 = exp_read(readRegister1);
            e2 = exp_read(readRegister2);
            checks++;
            if (readData1 !== e1 || readData2 !== e2) begin
                errors++;
                $display("FAIL rand_pre n=%0d rs1=%0d got=%h exp=%h rs2=%0d got=%h exp=%h",
                         n, readRegister1, readData1, e1, readRegister2, readData2, e2);
            end
            clock_edge();
            regWrite = 1'b0;
            #1;
            e1 = exp_read(readRegister1);
            e2 = exp_read(readRegister2);
            checks++;
            if (readData1 !== e1 || readData2 !== e2) begin
                errors++;
                $display("FAIL rand_post n=%0d rs1=%0d got=%h exp=%h rs2=%0d got=%h exp=%h",
                         n, readRegister1, readData1, e1, readRegister2, readData2, e2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_write_read();
        test_write_disable_fullwidth();
        test_x0();
        test_async_reset();
        test_same_cycle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
